// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - iterative 32-bit signed restoring divider
//
// Computes data_operandA / data_operandB (two's complement, truncated toward
// zero) one quotient bit per cycle. Ready pulses 33 edges after the start edge.
//
// Ports:
//   clock           system clock, rising-edge active
//   aclr_n          asynchronous active-low clear
//   ctrl_DIV        start strobe; restarts the operation in any state
//   data_operandA   dividend, sampled on start edges only
//   data_operandB   divisor, sampled on start edges only
//   data_result     signed quotient, held until the next completion or reset
//   data_exception  divide-by-zero flag, held like data_result
//   data_resultRDY  one-cycle completion pulse
module seq_divider (
  input  logic        clock,
  input  logic        aclr_n,
  input  logic        ctrl_DIV,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]  state_q,   state_d;
  logic [5:0]  count_q,   count_d;
  logic [63:0] rem_q,     rem_d;      // remainder:quotient shift register
  logic [31:0] divisor_q, divisor_d;  // |B|
  logic        sign_q,    sign_d;
  logic        div0_q,    div0_d;
  logic [31:0] result_q,  result_d;
  logic        exc_q,     exc_d;
  logic        rdy_q,     rdy_d;

  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [63:0] shifted;
  logic [32:0] diff;

  // Magnitudes as unsigned values, so |-2^31| is 0x80000000.
  assign abs_a = data_operandA[31] ? (~data_operandA + 32'd1) : data_operandA;
  assign abs_b = data_operandB[31] ? (~data_operandB + 32'd1) : data_operandB;

  // One restoring step: the 33rd bit of diff is the borrow (negative result).
  assign shifted = {rem_q[62:0], 1'b0};
  assign diff    = {1'b0, shifted[63:32]} - {1'b0, divisor_q};

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    rem_d     = rem_q;
    divisor_d = divisor_q;
    sign_d    = sign_q;
    div0_d    = div0_q;
    result_d  = result_q;
    exc_d     = exc_q;
    rdy_d     = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (count_q == 6'd32) begin
          // All 32 quotient bits are in rem_q[31:0]; publish at the DONE entry
          // edge so a coincident restart cannot swallow this result.
          state_d  = ST_DONE;
          rdy_d    = 1'b1;
          exc_d    = div0_q;
          if (div0_q) begin
            result_d = 32'd0;
          end else if (sign_q) begin
            result_d = ~rem_q[31:0] + 32'd1;
          end else begin
            result_d = rem_q[31:0];
          end
        end else begin
          if (diff[32]) begin
            rem_d = shifted;
          end else begin
            rem_d = {diff[31:0], shifted[31:1], 1'b1};
          end
          count_d = count_q + 6'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A start overrides whatever the sequencer was doing.
    if (ctrl_DIV) begin
      divisor_d = abs_b;
      sign_d    = data_operandA[31] ^ data_operandB[31];
      div0_d    = (data_operandB == 32'd0);
      rem_d     = {32'd0, abs_a};
      count_d   = 6'd0;
      state_d   = ST_RUN;
    end
  end

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q   <= ST_IDLE;
      count_q   <= 6'd0;
      rem_q     <= 64'd0;
      divisor_q <= 32'd0;
      sign_q    <= 1'b0;
      div0_q    <= 1'b0;
      result_q  <= 32'd0;
      exc_q     <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      rem_q     <= rem_d;
      divisor_q <= divisor_d;
      sign_q    <= sign_d;
      div0_q    <= div0_d;
      result_q  <= result_d;
      exc_q     <= exc_d;
      rdy_q     <= rdy_d;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - scoreboard testbench for seq_divider
module tb_seq_divider;

  logic        clock;
  logic        aclr_n;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  seq_divider dut (
    .clock          (clock),
    .aclr_n         (aclr_n),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain signed division at 64 bits, wrapped to 32; B==0 -> 0 with flag.
  task automatic model(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic e);
    longint q;
    if (b == 32'd0) begin
      r = 32'd0;
      e = 1'b1;
    end else begin
      q = longint'($signed(a)) / longint'($signed(b));
      r = q[31:0];
      e = 1'b0;
    end
  endtask

  // Called in the low clock phase; drives a start for one edge, then scrambles
  // the operands so any late sampling would corrupt the result.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input bit push);
    exp_t e;
    ctrl_DIV      = 1'b1;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
    #1;
    if (push) begin
      model(a, b, e.res, e.exc);
      e.cyc = cyc + 33;
      exp_q.push_back(e);
    end
    @(negedge clock);
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic run_one(input logic [31:0] a, input logic [31:0] b);
    start_op(a, b, 1'b1);
    repeat (34) @(negedge clock);
  endtask

  // Scoreboard monitor.
  always @(posedge clock) begin
    exp_t e;
    #1;
    if (data_resultRDY === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_ready: got ready at cycle %0d expected none", cyc);
      end else begin
        e = exp_q.pop_front();
        check("result", data_result, e.res);
        check("exception", {31'd0, data_exception}, {31'd0, e.exc});
        check("latency", cyc, e.cyc);
      end
    end
  end

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return $urandom_range(0, 3) == 0 ? 32'd0 : 32'hFFFF_FFFF;
      2: return 32'd1;
      3: return $urandom_range(0, 1000);
      4: return -$urandom_range(0, 1000);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int wait_cnt;
    int gap;
    logic [31:0] a;
    logic [31:0] b;
    aclr_n        = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = 32'd0;
    data_operandB = 32'd0;
    repeat (2) @(negedge clock);
    check("reset_result", data_result, 32'd0);
    check("reset_exception", {31'd0, data_exception}, 32'd0);
    check("reset_ready", {31'd0, data_resultRDY}, 32'd0);
    aclr_n = 1'b1;
    @(negedge clock);

    run_one(32'd100, 32'd7);
    run_one(-32'd100, 32'd7);
    run_one(32'd100, -32'd7);
    run_one(-32'd100, -32'd7);
    run_one(32'd7, 32'd100);
    run_one(32'd5, 32'd0);
    run_one(32'd6, 32'd3);
    run_one(32'h8000_0000, 32'd1);
    run_one(32'h8000_0000, 32'hFFFF_FFFF);
    run_one(32'h7FFF_FFFF, 32'h7FFF_FFFF);

    // Restart: second start 10 edges after the first, only one ready expected.
    start_op(32'd1000, 32'd10, 1'b0);
    repeat (9) @(negedge clock);
    run_one(32'd9, 32'd3);

    // ctrl_DIV held over three edges: only the last start counts.
    start_op(32'd50, 32'd2, 1'b0);
    start_op(32'd51, 32'd3, 1'b0);
    run_one(32'd77, 32'd7);

    // Back-to-back: new start exactly on the previous op's completion edge.
    start_op(32'd81, 32'd9, 1'b1);
    repeat (32) @(negedge clock);
    start_op(-32'd81, 32'd9, 1'b1);
    repeat (34) @(negedge clock);

    // Asynchronous reset between edges in the middle of RUN.
    start_op(32'd123, 32'd1, 1'b0);
    repeat (10) @(negedge clock);
    @(posedge clock);
    #2 aclr_n = 1'b0;
    #1;
    check("async_rst_result", data_result, 32'd0);
    check("async_rst_exception", {31'd0, data_exception}, 32'd0);
    check("async_rst_ready", {31'd0, data_resultRDY}, 32'd0);
    @(negedge clock);
    aclr_n = 1'b1;
    repeat (40) @(negedge clock);
    run_one(32'd20, 32'd4);

    // Randomized operands with gaps from back-to-back to idle.
    for (int i = 0; i < 40; i++) begin
      a   = rand_operand();
      b   = rand_operand();
      gap = $urandom_range(33, 36);
      start_op(a, b, 1'b1);
      repeat (gap - 1) @(negedge clock);
    end

    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 50) begin
      @(negedge clock);
      wait_cnt++;
    end
    check("scoreboard_drained", exp_q.size(), 32'd0);
    repeat (3) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
